mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port memory between instruction fetch (I side) and load/store access (D side) of the 5-stage core.
- Sits between IF/MEM stage memory nets and a unified, variable-latency memory.
- Grants one transaction at a time and holds the memory command stable until ack.
- Generates per-side stall requests for the hazard unit and flags a watchdog timeout.

Parameters:
- STARVE_LIMIT, 4, max consecutive D grants while I is pending before I is forced (1..15).
- TIMEOUT, 64, cycles mem_req may stay high without mem_ack before bus_err sets.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous active-low reset
- i_req  in  1  fetch request; held until i_ready
- i_addr  in  32  fetch byte address, word aligned
- i_rdata  out  32  fetch data, valid while i_ready
- i_ready  out  1  one-cycle completion pulse, I side
- d_req  in  1  data request; held until d_ready
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data byte address
- d_wdata  in  32  store data, already lane-merged
- d_rdata  out  32  load data, valid while d_ready
- d_ready  out  1  one-cycle completion pulse, D side
- mem_req  out  1  memory command valid
- mem_we  out  1  memory write enable
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid with mem_ack
- mem_ack  in  1  memory completion, exactly one cycle per command
- stallF  out  1  i_req & ~i_ready
- stallM  out  1  d_req & ~d_ready
- bus_err  out  1  sticky watchdog error

Behaviour:
- Reset values: mem_req, mem_we, i_ready, d_ready, bus_err = 0; mem_addr, mem_wdata, i_rdata, d_rdata = 0; FSM = IDLE; starve counter = 0; watchdog = 0.
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE with no request: stay in IDLE, mem_req = 0.
- IDLE, D is chosen: register d_addr, d_we, d_wdata into the mem_* outputs, set mem_req, go to BUSY_D.
- IDLE, I is chosen: register i_addr into mem_addr, set mem_we = 0, set mem_req, go to BUSY_I.
- Arbitration order:
  - D wins over I (the older instruction completes first).
  - Exception: when starve_cnt == STARVE_LIMIT and i_req = 1, I wins.
- Starve counter rules:
  - Increments on each D grant made while i_req = 1, saturating at STARVE_LIMIT.
  - Clears on any I grant.
  - Clears on any D grant made while i_req = 0.
- BUSY_x: mem_* outputs are held constant until mem_ack.
- mem_ack cycle:
  - x_ready = 1 combinationally.
  - x_rdata = mem_rdata as a passthrough (I side and D loads; D stores pass it through too, value don't-care).
  - mem_req drops next cycle; FSM returns to IDLE.
- Latency: request visible in IDLE at cycle t -> mem_req high at t+1 -> ready in the mem_ack cycle, t+1+L with L >= 0.
- Throughput: minimum 2 cycles per transaction, since IDLE always takes one arbitration cycle.
- mem_ack while in IDLE is ignored.
- A requester dropping req before ready is a protocol violation: the transaction still completes and ready still pulses.
- Req and addr changes while BUSY are ignored until the next IDLE arbitration.
- Both requests asserted with starve_cnt < STARVE_LIMIT: D is granted; stallF remains 1.
- Watchdog:
  - Counts cycles in BUSY_x without mem_ack.
  - At count == TIMEOUT: set bus_err, force the FSM to IDLE, drop mem_req, and pulse x_ready with rdata = 32'hDEAD_BEEF so the pipeline does not hang.
  - bus_err clears only on reset.
- Reset asserted mid-transaction: immediate return to reset values; the in-flight memory op is abandoned, and the memory must tolerate mem_req dropping.
- Counter widths: starve counter 4 bits; watchdog $clog2(TIMEOUT+1) bits.

Decomposition:
- Shared package mem_arb_pkg: typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} arb_state_t; localparam DEADBEEF = 32'hDEAD_BEEF; typedef struct {we, addr, wdata} mem_cmd_t.
- One sub-module: arb_watchdog (counter, compare, sticky bus_err), instantiated once.

Test Plan:
- Reset, then i_req with i_addr=32'h100, L=2 -> mem_req=1 one cycle after the request, mem_addr=32'h100, mem_we=0; i_ready pulses 3 cycles after the request with i_rdata = mem_rdata (e.g. 32'h00500093).
- i_req and d_req both high from IDLE, d_we=1, d_addr=32'h2000, d_wdata=32'h12345678 -> D served first with mem_we=1 and wdata=32'h12345678; I served in the next arbitration; stallF high throughout.
- i_req held high, d_req re-asserted after every d_ready, STARVE_LIMIT=4 -> exactly 4 D grants, then 1 I grant; starve counter back to 0.
- Memory never acks, TIMEOUT=64 -> after 64 busy cycles bus_err=1, d_ready pulses with d_rdata=32'hDEADBEEF, mem_req=0, FSM in IDLE; bus_err still 1 after 100 further cycles.
- reset driven low in BUSY_D with mem_req=1 -> mem_req, d_ready and bus_err go 0 the same cycle (asynchronous); after release the arbiter accepts a new i_req normally.
- Spurious mem_ack in IDLE with no requests -> no ready pulse, state stays IDLE.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the I/D memory port arbiter.
// Holds the FSM state type, the latched memory command and the starve-counter helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  localparam logic [31:0] DEADBEEF = 32'hDEAD_BEEF;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_cmd_t;

  localparam mem_cmd_t CMD_RESET = '{we: 1'b0, addr: 32'h0000_0000, wdata: 32'h0000_0000};

  function automatic logic [3:0] sat_inc4(input logic [3:0] val, input logic [3:0] lim);
    logic [3:0] res;
    if (val >= lim) begin
      res = lim;
    end else begin
      res = val + 4'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, load/store, memory and status nets around the arbiter.
// slave = arbiter view, master = core pipeline plus memory view.
interface mem_port_arbiter_if;
  import mem_arb_pkg::*;

  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ready;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stallF;
  logic        stallM;
  logic        bus_err;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    output i_rdata, i_ready, d_rdata, d_ready, mem_req, mem_we, mem_addr, mem_wdata,
           stallF, stallM, bus_err
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    input  i_rdata, i_ready, d_rdata, d_ready, mem_req, mem_we, mem_addr, mem_wdata,
           stallF, stallM, bus_err
  );

endinterface

// File: rtl/mem_port_arbiter_watchdog.sv
// Busy-cycle watchdog: counts unacknowledged busy cycles and raises a sticky bus error.
// timeout is combinational so the arbiter can complete the stuck transaction in the same cycle.
module arb_watchdog
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic busy,
  input  logic ack,
  output logic timeout,
  output logic bus_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          bus_err_q, bus_err_d;
  logic          timeout_s;

  // Timeout detection and next-state for counter and sticky error
  always_comb begin
    timeout_s = busy & ~ack & (cnt_q == CNT_LIMIT);
    cnt_d     = '0;
    if (busy && !ack && !timeout_s) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = '0;
    end
    bus_err_d = bus_err_q | timeout_s;
  end

  // Counter and sticky error registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign timeout = timeout_s;
  assign bus_err = bus_err_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store.
// D wins arbitration unless I has been passed over STARVE_LIMIT times in a row.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input logic            clk,
  input logic            reset,
  mem_port_arbiter_if.slave bus
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  arb_state_t  state_q, state_d;
  mem_cmd_t    cmd_q, cmd_d;
  logic        mem_req_q, mem_req_d;
  logic [3:0]  starve_q, starve_d;

  logic        grant_i_s;
  logic        grant_d_s;
  logic        busy_s;
  logic        timeout_s;
  logic        bus_err_s;
  logic        i_ready_s;
  logic        d_ready_s;
  logic [31:0] rsp_data_s;
  logic [31:0] i_rdata_s;
  logic [31:0] d_rdata_s;

  assign busy_s = (state_q != IDLE);

  arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .busy    (busy_s),
    .ack     (bus.mem_ack),
    .timeout (timeout_s),
    .bus_err (bus_err_s)
  );

  // Arbitration and next-state logic
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    mem_req_d = mem_req_q;
    starve_d  = starve_q;
    grant_i_s = bus.i_req & (~bus.d_req | (starve_q == STARVE_MAX));
    grant_d_s = bus.d_req & ~grant_i_s;
    case (state_q)
      IDLE: begin
        if (grant_d_s) begin
          cmd_d     = '{we: bus.d_we, addr: bus.d_addr, wdata: bus.d_wdata};
          mem_req_d = 1'b1;
          state_d   = BUSY_D;
          starve_d  = bus.i_req ? sat_inc4(starve_q, STARVE_MAX) : 4'd0;
        end else if (grant_i_s) begin
          cmd_d     = '{we: 1'b0, addr: bus.i_addr, wdata: 32'h0000_0000};
          mem_req_d = 1'b1;
          state_d   = BUSY_I;
          starve_d  = 4'd0;
        end else begin
          mem_req_d = 1'b0;
        end
      end
      BUSY_I, BUSY_D: begin
        // Command stays frozen until the memory answers or the watchdog gives up
        if (bus.mem_ack || timeout_s) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end else begin
          mem_req_d = 1'b1;
        end
      end
      default: begin
        mem_req_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  // Arbiter state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cmd_q     <= CMD_RESET;
      mem_req_q <= 1'b0;
      starve_q  <= 4'd0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      mem_req_q <= mem_req_d;
      starve_q  <= starve_d;
    end
  end

  // Completion pulses; a watchdog abort answers with the poison word
  always_comb begin
    rsp_data_s = bus.mem_ack ? bus.mem_rdata : DEADBEEF;
    i_ready_s  = 1'b0;
    d_ready_s  = 1'b0;
    if (state_q == BUSY_I) begin
      i_ready_s = bus.mem_ack | timeout_s;
    end else if (state_q == BUSY_D) begin
      d_ready_s = bus.mem_ack | timeout_s;
    end else begin
      i_ready_s = 1'b0;
      d_ready_s = 1'b0;
    end
    i_rdata_s = i_ready_s ? rsp_data_s : 32'h0000_0000;
    d_rdata_s = d_ready_s ? rsp_data_s : 32'h0000_0000;
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = cmd_q.we;
  assign bus.mem_addr  = cmd_q.addr;
  assign bus.mem_wdata = cmd_q.wdata;
  assign bus.i_ready   = i_ready_s;
  assign bus.d_ready   = d_ready_s;
  assign bus.i_rdata   = i_rdata_s;
  assign bus.d_rdata   = d_rdata_s;
  assign bus.stallF    = bus.i_req & ~i_ready_s;
  assign bus.stallM    = bus.d_req & ~d_ready_s;
  assign bus.bus_err   = bus_err_s;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table plus sequences
// for starvation, watchdog timeout and asynchronous reset.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic clk;
  logic reset;
  int   total;
  int   passed;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        ack;
    logic [31:0] rdata;
    logic        e_req;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_iready;
    logic        e_dready;
    logic [31:0] e_rdata;
    logic        e_stallf;
    logic        e_stallm;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end else begin
      passed++;
    end
  endtask

  // Wait (bounded) for mem_req, sampling 1 time unit after each rising edge
  task automatic wait_req(output bit ok);
    int n;
    n = 0;
    while (bus.mem_req !== 1'b1 && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    ok = (bus.mem_req === 1'b1);
    if (!ok) begin
      total++;
      $display("FAIL grant_wait: got mem_req=%b expected 1 within 10 cycles", bus.mem_req);
    end
  endtask

  // Acknowledge the pending command immediately and report which side completed
  task automatic serve(output logic [31:0] addr_o, output logic ir, output logic dr);
    bit ok;
    wait_req(ok);
    addr_o        = bus.mem_addr;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    ir = bus.i_ready;
    dr = bus.d_ready;
    @(posedge clk);
    #1;
    bus.mem_ack = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    logic        ir, dr;
    bit          ok;
    bit          early;
    total  = 0;
    passed = 0;

    //         i_req i_addr        d_req we    d_addr        d_wdata       ack   rdata         e_req e_we  e_addr        e_wdata       irdy  drdy  e_rdata       stF   stM
    tbl[0]  = '{1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 1'b0};
    tbl[1]  = '{1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0100, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 1'b0};
    tbl[2]  = '{1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0100, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 1'b0};
    tbl[3]  = '{1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0050_0093, 1'b1, 1'b0, 32'h0000_0100, 32'h0,         1'b1, 1'b0, 32'h0050_0093, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 32'h0000_0100, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0000_0100, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 1'b0};
    tbl[5]  = '{1'b1, 32'h0000_0104, 1'b1, 1'b1, 32'h0000_2000, 32'h1234_5678, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0000_0100, 32'h0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1};
    tbl[6]  = '{1'b1, 32'h0000_0104, 1'b1, 1'b1, 32'h0000_2000, 32'h1234_5678, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_2000, 32'h1234_5678, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1};
    tbl[7]  = '{1'b1, 32'h0000_0104, 1'b1, 1'b1, 32'h0000_2000, 32'h1234_5678, 1'b1, 32'hAAAA_5555, 1'b1, 1'b1, 32'h0000_2000, 32'h1234_5678, 1'b0, 1'b1, 32'hAAAA_5555, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 32'h0000_0104, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_2000, 32'h1234_5678, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0};
    tbl[9]  = '{1'b1, 32'h0000_0104, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0104, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 1'b0};
    tbl[10] = '{1'b1, 32'h0000_0104, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h1122_3344, 1'b1, 1'b0, 32'h0000_0104, 32'h0,         1'b1, 1'b0, 32'h1122_3344, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0000_0104, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 1'b0};
    tbl[12] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0000_0055, 1'b0, 1'b0, 32'h0000_0104, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 1'b0};
    tbl[13] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0000_0104, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 1'b0};

    reset         = 1'b0;
    bus.i_req     = 1'b0;
    bus.i_addr    = 32'h0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_addr    = 32'h0;
    bus.d_wdata   = 32'h0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;

    repeat (2) @(negedge clk);
    chk("rst_mem_req",   32'(bus.mem_req), 32'h0);
    chk("rst_mem_we",    32'(bus.mem_we), 32'h0);
    chk("rst_mem_addr",  bus.mem_addr, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk("rst_i_ready",   32'(bus.i_ready), 32'h0);
    chk("rst_d_ready",   32'(bus.d_ready), 32'h0);
    chk("rst_i_rdata",   bus.i_rdata, 32'h0);
    chk("rst_d_rdata",   bus.d_rdata, 32'h0);
    chk("rst_bus_err",   32'(bus.bus_err), 32'h0);
    reset = 1'b1;

    // Per-cycle vectors: single fetch, D-over-I, spurious ack in IDLE
    for (int i = 0; i < 14; i++) begin
      @(posedge clk);
      #1;
      bus.i_req     = tbl[i].i_req;
      bus.i_addr    = tbl[i].i_addr;
      bus.d_req     = tbl[i].d_req;
      bus.d_we      = tbl[i].d_we;
      bus.d_addr    = tbl[i].d_addr;
      bus.d_wdata   = tbl[i].d_wdata;
      bus.mem_ack   = tbl[i].ack;
      bus.mem_rdata = tbl[i].rdata;
      @(negedge clk);
      chk($sformatf("v%0d_mem_req", i),   32'(bus.mem_req), 32'(tbl[i].e_req));
      chk($sformatf("v%0d_mem_we", i),    32'(bus.mem_we), 32'(tbl[i].e_we));
      chk($sformatf("v%0d_mem_addr", i),  bus.mem_addr, tbl[i].e_addr);
      chk($sformatf("v%0d_mem_wdata", i), bus.mem_wdata, tbl[i].e_wdata);
      chk($sformatf("v%0d_i_ready", i),   32'(bus.i_ready), 32'(tbl[i].e_iready));
      chk($sformatf("v%0d_d_ready", i),   32'(bus.d_ready), 32'(tbl[i].e_dready));
      chk($sformatf("v%0d_stallF", i),    32'(bus.stallF), 32'(tbl[i].e_stallf));
      chk($sformatf("v%0d_stallM", i),    32'(bus.stallM), 32'(tbl[i].e_stallm));
      if (tbl[i].e_iready) chk($sformatf("v%0d_i_rdata", i), bus.i_rdata, tbl[i].e_rdata);
      if (tbl[i].e_dready) chk($sformatf("v%0d_d_rdata", i), bus.d_rdata, tbl[i].e_rdata);
    end
    chk("spurious_ack_idle", 32'(dut.state_q), 32'(IDLE));
    bus.mem_ack = 1'b0;

    // Starvation: I held, D always pending -> D,D,D,D then I
    @(posedge clk);
    #1;
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h0000_0300;
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h0000_4000;
    for (int g = 0; g < 5; g++) begin
      serve(a, ir, dr);
      if (g < 4) begin
        chk($sformatf("starve_g%0d_addr", g), a, 32'h0000_4000);
        chk($sformatf("starve_g%0d_dready", g), 32'(dr), 32'h1);
        chk($sformatf("starve_g%0d_iready", g), 32'(ir), 32'h0);
      end else begin
        chk("starve_i_addr", a, 32'h0000_0300);
        chk("starve_i_iready", 32'(ir), 32'h1);
        chk("starve_i_dready", 32'(dr), 32'h0);
      end
      if (g == 3) chk("starve_cnt_sat", 32'(dut.starve_q), 32'h4);
    end
    chk("starve_cnt_clear", 32'(dut.starve_q), 32'h0);
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;

    // Watchdog: memory never acks a load
    @(posedge clk);
    #1;
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h0000_5000;
    wait_req(ok);
    early = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      if (bus.d_ready !== 1'b0) early = 1'b1;
      @(posedge clk);
      #1;
    end
    chk("wd_no_early_ready", 32'(early), 32'h0);
    @(negedge clk);
    chk("wd_d_ready", 32'(bus.d_ready), 32'h1);
    chk("wd_d_rdata", bus.d_rdata, 32'hDEAD_BEEF);
    @(posedge clk);
    #1;
    bus.d_req = 1'b0;
    chk("wd_mem_req_drop", 32'(bus.mem_req), 32'h0);
    chk("wd_bus_err", 32'(bus.bus_err), 32'h1);
    chk("wd_state_idle", 32'(dut.state_q), 32'(IDLE));
    repeat (100) @(posedge clk);
    #1;
    chk("wd_bus_err_sticky", 32'(bus.bus_err), 32'h1);

    // Asynchronous reset in the middle of a store
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h0000_7000;
    bus.d_wdata = 32'h0000_CAFE;
    wait_req(ok);
    bus.mem_ack = 1'b1;
    #1;
    chk("ar_pre_d_ready", 32'(bus.d_ready), 32'h1);
    #1;
    reset = 1'b0;
    #1;
    chk("ar_mem_req", 32'(bus.mem_req), 32'h0);
    chk("ar_d_ready", 32'(bus.d_ready), 32'h0);
    chk("ar_bus_err", 32'(bus.bus_err), 32'h0);
    @(negedge clk);
    bus.mem_ack = 1'b0;
    bus.d_req   = 1'b0;
    reset       = 1'b1;
    @(posedge clk);
    #1;
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h0000_0600;
    wait_req(ok);
    chk("ar_i_addr", bus.mem_addr, 32'h0000_0600);
    chk("ar_i_we", 32'(bus.mem_we), 32'h0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h0000_0013;
    #1;
    chk("ar_i_ready", 32'(bus.i_ready), 32'h1);
    chk("ar_i_rdata", bus.i_rdata, 32'h0000_0013);
    @(posedge clk);
    #1;
    bus.mem_ack = 1'b0;
    bus.i_req   = 1'b0;
    chk("ar_done_req", 32'(bus.mem_req), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
